// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned PWM_N_CH  = 4;
    localparam int unsigned PWM_WIDTH = 8;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Configuration and status bundle between a PWM controller and the generator.
interface pwm_multi_channel_if
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH  = PWM_N_CH,
    parameter int unsigned WIDTH = PWM_WIDTH
) ();

    logic                    startPWM;
    logic [WIDTH-1:0]        period;
    logic [N_CH*WIDTH-1:0]   duty;
    logic [N_CH-1:0]         polarity;
    logic                    center_mode;
    logic                    load;
    logic                    load_pending;
    logic                    period_end;
    logic [WIDTH-1:0]        count;
    logic [N_CH-1:0]         out;

    modport master (
        output startPWM, period, duty, polarity, center_mode, load,
        input  load_pending, period_end, count, out
    );

    modport slave (
        input  startPWM, period, duty, polarity, center_mode, load,
        output load_pending, period_end, count, out
    );

endinterface

// File: rtl/pwm_compare_channel.sv
// One PWM channel: duty/polarity compare against the next-state count, registered output.
module pwm_compare_channel
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_nxt,
    input  logic [WIDTH-1:0] duty,
    input  logic             pol,
    output logic             out_q
);

    logic out_d;

    always_comb begin
        out_d = pol;
        if (enable) begin
            out_d = (count_nxt < duty) ^ pol;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM with shared edge/center-aligned counter and double-buffered configuration.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH  = PWM_N_CH,
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic                 clock,
    input  logic                 resetPWM,
    pwm_multi_channel_if.slave   bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]      count_q, count_d;
    pwm_dir_e              dir_q, dir_d;
    logic                  run_q, run_d;
    logic [WIDTH-1:0]      per_act_q, per_act_d, per_pend_q, per_pend_d;
    logic [N_CH*WIDTH-1:0] duty_act_q, duty_act_d, duty_pend_q, duty_pend_d;
    logic [N_CH-1:0]       pol_act_q, pol_act_d, pol_pend_q, pol_pend_d;
    logic                  mode_act_q, mode_act_d, mode_pend_q, mode_pend_d;
    logic                  load_pending_q, load_pending_d;
    logic                  period_end_q, period_end_d;
    logic                  apply;
    logic                  enable_d;
    logic [N_CH-1:0]       out_q;

    always_comb begin
        count_d        = count_q;
        dir_d          = dir_q;
        run_d          = bus.startPWM;
        per_act_d      = per_act_q;
        duty_act_d     = duty_act_q;
        pol_act_d      = pol_act_q;
        mode_act_d     = mode_act_q;
        per_pend_d     = per_pend_q;
        duty_pend_d    = duty_pend_q;
        pol_pend_d     = pol_pend_q;
        mode_pend_d    = mode_pend_q;
        load_pending_d = load_pending_q;

        // Pending applies at a period boundary, or at once while nothing is actually counting.
        apply = load_pending_q &&
                (period_end_q || !run_q || !bus.startPWM || per_act_q == '0);

        if (apply) begin
            per_act_d      = per_pend_q;
            duty_act_d     = duty_pend_q;
            pol_act_d      = pol_pend_q;
            mode_act_d     = mode_pend_q;
            load_pending_d = 1'b0;
        end

        // A capture in the same cycle as an apply stays pending for the next boundary.
        if (bus.load) begin
            per_pend_d     = bus.period;
            duty_pend_d    = bus.duty;
            pol_pend_d     = bus.polarity;
            mode_pend_d    = bus.center_mode;
            load_pending_d = 1'b1;
        end

        if (!bus.startPWM || !run_q || apply || per_act_q == '0) begin
            count_d = '0;
            dir_d   = DIR_UP;
        end else if (mode_act_q == PWM_EDGE) begin
            count_d = (count_q >= per_act_q - ONE) ? '0 : count_q + ONE;
        end else if (dir_q == DIR_UP) begin
            count_d = count_q + ONE;
            if (count_d >= per_act_q) begin
                dir_d = DIR_DOWN;
            end
        end else if (count_q <= ONE) begin
            count_d = '0;
            dir_d   = DIR_UP;
        end else begin
            count_d = count_q - ONE;
        end

        enable_d = run_d && (per_act_d != '0);

        period_end_d = 1'b0;
        if (enable_d) begin
            if (mode_act_d == PWM_CENTER) begin
                period_end_d = (dir_d == DIR_DOWN) && (count_d == ONE);
            end else begin
                period_end_d = (count_d == per_act_d - ONE);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resetPWM) begin
            count_q        <= '0;
            dir_q          <= DIR_UP;
            run_q          <= 1'b0;
            per_act_q      <= '0;
            duty_act_q     <= '0;
            pol_act_q      <= '0;
            mode_act_q     <= PWM_EDGE;
            per_pend_q     <= '0;
            duty_pend_q    <= '0;
            pol_pend_q     <= '0;
            mode_pend_q    <= PWM_EDGE;
            load_pending_q <= 1'b0;
            period_end_q   <= 1'b0;
        end else begin
            count_q        <= count_d;
            dir_q          <= dir_d;
            run_q          <= run_d;
            per_act_q      <= per_act_d;
            duty_act_q     <= duty_act_d;
            pol_act_q      <= pol_act_d;
            mode_act_q     <= mode_act_d;
            per_pend_q     <= per_pend_d;
            duty_pend_q    <= duty_pend_d;
            pol_pend_q     <= pol_pend_d;
            mode_pend_q    <= mode_pend_d;
            load_pending_q <= load_pending_d;
            period_end_q   <= period_end_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_compare_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk       (clock),
            .rst       (resetPWM),
            .enable    (enable_d),
            .count_nxt (count_d),
            .duty      (duty_act_d[i*WIDTH +: WIDTH]),
            .pol       (pol_act_d[i]),
            .out_q     (out_q[i])
        );
    end

    assign bus.count        = count_q;
    assign bus.period_end   = period_end_q;
    assign bus.load_pending = load_pending_q;
    assign bus.out          = out_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed self-checking bench for pwm_multi_channel (4 channels, 8-bit).
module tb_pwm_multi_channel;

    logic clock;
    logic resetPWM;
    int   total;
    int   bad;

    pwm_multi_channel_if #(.N_CH(4), .WIDTH(8)) bus ();

    pwm_multi_channel #(.N_CH(4), .WIDTH(8)) dut (
        .clock    (clock),
        .resetPWM (resetPWM),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [7:0] p, input logic [31:0] d,
                           input logic [3:0] pol, input logic cm);
        bus.period      = p;
        bus.duty        = d;
        bus.polarity    = pol;
        bus.center_mode = cm;
        bus.load        = 1'b1;
        tick();
        bus.load        = 1'b0;
    endtask

    task automatic wait_pe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.period_end === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        resetPWM = 1'b1;
        tick();
        tick();
        resetPWM = 1'b0;
        total++; if (bus.count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.out !== 4'b0000) begin bad++; $display("FAIL reset_out got=%b exp=0000", bus.out); end
        total++; if (bus.load_pending !== 1'b0) begin bad++; $display("FAIL reset_lp got=%b exp=0", bus.load_pending); end
        total++; if (bus.period_end !== 1'b0) begin bad++; $display("FAIL reset_pe got=%b exp=0", bus.period_end); end
    endtask

    task automatic test_edge();
        logic [3:0] e;
        int c;
        do_load(8'd10, {8'd12, 8'd10, 8'd3, 8'd0}, 4'b0000, 1'b0);
        total++; if (bus.load_pending !== 1'b1) begin bad++; $display("FAIL edge_lp_set got=%b exp=1", bus.load_pending); end
        bus.startPWM = 1'b1;
        tick();
        total++; if (bus.load_pending !== 1'b0) begin bad++; $display("FAIL edge_lp_clr got=%b exp=0", bus.load_pending); end
        for (int k = 0; k < 20; k++) begin
            c = k % 10;
            e = {1'b1, 1'b1, (c < 3), 1'b0};
            total++; if (bus.count !== 8'(c)) begin bad++; $display("FAIL edge_count k=%0d got=%0d exp=%0d", k, bus.count, c); end
            total++; if (bus.out !== e) begin bad++; $display("FAIL edge_out k=%0d got=%b exp=%b", k, bus.out, e); end
            total++; if (bus.period_end !== (c == 9)) begin bad++; $display("FAIL edge_pe k=%0d got=%b exp=%b", k, bus.period_end, (c == 9)); end
            tick();
        end
    endtask

    task automatic test_reload();
        logic [3:0] e;
        int c;
        for (int i = 0; i < 4; i++) tick();
        do_load(8'd6, {8'd12, 8'd10, 8'd2, 8'd0}, 4'b0000, 1'b0);
        total++; if (bus.count !== 8'd5) begin bad++; $display("FAIL reload_count5 got=%0d exp=5", bus.count); end
        total++; if (bus.load_pending !== 1'b1) begin bad++; $display("FAIL reload_lp5 got=%b exp=1", bus.load_pending); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (bus.count !== 8'd9 || bus.period_end !== 1'b1) begin bad++; $display("FAIL reload_end count=%0d pe=%b exp=9/1", bus.count, bus.period_end); end
        total++; if (bus.load_pending !== 1'b1) begin bad++; $display("FAIL reload_lp9 got=%b exp=1", bus.load_pending); end
        tick();
        total++; if (bus.load_pending !== 1'b0) begin bad++; $display("FAIL reload_lp_clr got=%b exp=0", bus.load_pending); end
        for (int k = 0; k < 12; k++) begin
            c = k % 6;
            e = {1'b1, 1'b1, (c < 2), 1'b0};
            total++; if (bus.count !== 8'(c)) begin bad++; $display("FAIL reload_count k=%0d got=%0d exp=%0d", k, bus.count, c); end
            total++; if (bus.out !== e) begin bad++; $display("FAIL reload_out k=%0d got=%b exp=%b", k, bus.out, e); end
            total++; if (bus.period_end !== (c == 5)) begin bad++; $display("FAIL reload_pe k=%0d got=%b exp=%b", k, bus.period_end, (c == 5)); end
            tick();
        end
    endtask

    task automatic test_center();
        int seq [8];
        logic [3:0] e;
        bit ok;
        seq = '{0, 1, 2, 3, 4, 3, 2, 1};
        do_load(8'd4, {4{8'd2}}, 4'b0000, 1'b1);
        wait_pe(ok);
        total++; if (!ok) begin bad++; $display("FAIL center_wait got=timeout exp=period_end"); end
        tick();
        for (int k = 0; k < 16; k++) begin
            e = (seq[k % 8] < 2) ? 4'b1111 : 4'b0000;
            total++; if (bus.count !== 8'(seq[k % 8])) begin bad++; $display("FAIL center_count k=%0d got=%0d exp=%0d", k, bus.count, seq[k % 8]); end
            total++; if (bus.out !== e) begin bad++; $display("FAIL center_out k=%0d got=%b exp=%b", k, bus.out, e); end
            total++; if (bus.period_end !== ((k % 8) == 7)) begin bad++; $display("FAIL center_pe k=%0d got=%b exp=%b", k, bus.period_end, ((k % 8) == 7)); end
            tick();
        end
    endtask

    task automatic test_stop();
        bit ok;
        do_load(8'd10, {8'd12, 8'd10, 8'd3, 8'd0}, 4'b1010, 1'b0);
        wait_pe(ok);
        total++; if (!ok) begin bad++; $display("FAIL stop_wait got=timeout exp=period_end"); end
        tick();
        total++; if (bus.count !== 8'd0 || bus.out !== 4'b0100) begin bad++; $display("FAIL stop_run0 count=%0d out=%b exp=0/0100", bus.count, bus.out); end
        for (int i = 0; i < 5; i++) tick();
        total++; if (bus.count !== 8'd5 || bus.out !== 4'b0110) begin bad++; $display("FAIL stop_run5 count=%0d out=%b exp=5/0110", bus.count, bus.out); end
        bus.startPWM = 1'b0;
        tick();
        total++; if (bus.count !== 8'd0 || bus.out !== 4'b1010 || bus.period_end !== 1'b0) begin bad++; $display("FAIL stop_halt count=%0d out=%b pe=%b exp=0/1010/0", bus.count, bus.out, bus.period_end); end
        do_load(8'd5, {4{8'd2}}, 4'b0000, 1'b0);
        total++; if (bus.load_pending !== 1'b1) begin bad++; $display("FAIL stop_lp_set got=%b exp=1", bus.load_pending); end
        tick();
        total++; if (bus.load_pending !== 1'b0 || bus.out !== 4'b0000) begin bad++; $display("FAIL stop_apply lp=%b out=%b exp=0/0000", bus.load_pending, bus.out); end
        bus.startPWM = 1'b1;
        tick();
        total++; if (bus.count !== 8'd0 || bus.out !== 4'b1111) begin bad++; $display("FAIL stop_restart0 count=%0d out=%b exp=0/1111", bus.count, bus.out); end
        tick();
        total++; if (bus.count !== 8'd1 || bus.out !== 4'b1111) begin bad++; $display("FAIL stop_restart1 count=%0d out=%b exp=1/1111", bus.count, bus.out); end
        tick();
        total++; if (bus.count !== 8'd2 || bus.out !== 4'b0000) begin bad++; $display("FAIL stop_restart2 count=%0d out=%b exp=2/0000", bus.count, bus.out); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_load(8'd10, {4{8'd2}}, 4'b0000, 1'b0);
        wait_pe(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_wait got=timeout exp=period_end"); end
        tick();
        for (int i = 0; i < 6; i++) tick();
        do_load(8'd3, {4{8'd1}}, 4'b0000, 1'b0);
        total++; if (bus.count !== 8'd7 || bus.load_pending !== 1'b1) begin bad++; $display("FAIL rmid_pre count=%0d lp=%b exp=7/1", bus.count, bus.load_pending); end
        resetPWM = 1'b1;
        tick();
        resetPWM = 1'b0;
        total++; if (bus.count !== 8'd0 || bus.out !== 4'b0000 || bus.load_pending !== 1'b0) begin bad++; $display("FAIL rmid_post count=%0d out=%b lp=%b exp=0/0000/0", bus.count, bus.out, bus.load_pending); end
        for (int k = 0; k < 15; k++) begin
            tick();
            total++; if (bus.count !== 8'd0 || bus.period_end !== 1'b0 || bus.out !== 4'b0000) begin bad++; $display("FAIL rmid_idle k=%0d count=%0d pe=%b out=%b exp=0/0/0000", k, bus.count, bus.period_end, bus.out); end
        end
        do_load(8'd3, {4{8'd1}}, 4'b0000, 1'b0);
        total++; if (bus.load_pending !== 1'b1 || bus.count !== 8'd0) begin bad++; $display("FAIL rmid_load lp=%b count=%0d exp=1/0", bus.load_pending, bus.count); end
        tick();
        total++; if (bus.count !== 8'd0 || bus.out !== 4'b1111 || bus.load_pending !== 1'b0) begin bad++; $display("FAIL rmid_apply count=%0d out=%b lp=%b exp=0/1111/0", bus.count, bus.out, bus.load_pending); end
        tick();
        total++; if (bus.count !== 8'd1 || bus.out !== 4'b0000) begin bad++; $display("FAIL rmid_c1 count=%0d out=%b exp=1/0000", bus.count, bus.out); end
        tick();
        total++; if (bus.count !== 8'd2 || bus.period_end !== 1'b1) begin bad++; $display("FAIL rmid_c2 count=%0d pe=%b exp=2/1", bus.count, bus.period_end); end
        tick();
        total++; if (bus.count !== 8'd0) begin bad++; $display("FAIL rmid_wrap count=%0d exp=0", bus.count); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [3:0] e;
        do_load(8'd4, {4{8'd1}}, 4'b0000, 1'b0);
        wait_pe(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_wait1 got=timeout exp=period_end"); end
        do_load(8'd5, {4{8'd4}}, 4'b0000, 1'b0);
        total++; if (bus.count !== 8'd0 || bus.out !== 4'b1111 || bus.load_pending !== 1'b1) begin bad++; $display("FAIL b2b_boundary count=%0d out=%b lp=%b exp=0/1111/1", bus.count, bus.out, bus.load_pending); end
        tick();
        total++; if (bus.count !== 8'd1 || bus.out !== 4'b0000) begin bad++; $display("FAIL b2b_a1 count=%0d out=%b exp=1/0000", bus.count, bus.out); end
        tick();
        tick();
        total++; if (bus.count !== 8'd3 || bus.period_end !== 1'b1) begin bad++; $display("FAIL b2b_a3 count=%0d pe=%b exp=3/1", bus.count, bus.period_end); end
        tick();
        total++; if (bus.count !== 8'd0 || bus.load_pending !== 1'b0 || bus.out !== 4'b1111) begin bad++; $display("FAIL b2b_b0 count=%0d lp=%b out=%b exp=0/0/1111", bus.count, bus.load_pending, bus.out); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (bus.count !== 8'd4 || bus.out !== 4'b0000 || bus.period_end !== 1'b1) begin bad++; $display("FAIL b2b_b4 count=%0d out=%b pe=%b exp=4/0000/1", bus.count, bus.out, bus.period_end); end
        do_load(8'd6, {4{8'd1}}, 4'b0000, 1'b0);
        do_load(8'd7, {4{8'd3}}, 4'b0000, 1'b0);
        total++; if (bus.load_pending !== 1'b1) begin bad++; $display("FAIL b2b_lp got=%b exp=1", bus.load_pending); end
        wait_pe(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_wait2 got=timeout exp=period_end"); end
        tick();
        for (int k = 0; k < 7; k++) begin
            e = (k < 3) ? 4'b1111 : 4'b0000;
            total++; if (bus.count !== 8'(k)) begin bad++; $display("FAIL b2b_d_count k=%0d got=%0d exp=%0d", k, bus.count, k); end
            total++; if (bus.out !== e) begin bad++; $display("FAIL b2b_d_out k=%0d got=%b exp=%b", k, bus.out, e); end
            total++; if (bus.period_end !== (k == 6)) begin bad++; $display("FAIL b2b_d_pe k=%0d got=%b exp=%b", k, bus.period_end, (k == 6)); end
            tick();
        end
        total++; if (bus.count !== 8'd0) begin bad++; $display("FAIL b2b_d_wrap count=%0d exp=0", bus.count); end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        resetPWM         = 1'b1;
        bus.startPWM     = 1'b0;
        bus.period       = '0;
        bus.duty         = '0;
        bus.polarity     = '0;
        bus.center_mode  = 1'b0;
        bus.load         = 1'b0;
        test_reset();
        test_edge();
        test_reload();
        test_center();
        test_stop();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
